if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core and the writer of the 64-bit IF/ID pipeline register consumed by the ID-stage decoder. It owns the PC and issues requests to instruction memory using a req/ready handshake. It packs `{PC+4, instruction}` into `ifid_reg`. It honours hazard stalls without losing a returned instruction, and redirects on jump or branch by flushing IF/ID to a bubble.

---
 rtl/if_fetch_unit.sv | 97 +++++++++
 tb/tb_if_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// writes the IF/ID register, with a one-entry skid buffer for hazard stalls.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        jump_en,
   input  logic [31:0] jump_target,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [63:0] ifid_reg,
   output logic        ifid_valid
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned IFID_W = 2 * XLEN;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_pc;
   logic [IFID_W-1:0] r_ifid;
   logic              r_ifid_valid;
   logic [IFID_W-1:0] r_skid;

   logic              w_redirect;
   logic [XLEN-1:0]   w_target;
   logic [XLEN-1:0]   w_pc_plus4;
   logic [IFID_W-1:0] w_fetched;

   // The EX-stage branch is older than the ID-stage jump, so it wins.
   assign w_redirect = branch_en | jump_en;
   assign w_target   = branch_en ? branch_target : jump_target;
   assign w_pc_plus4 = r_pc + XLEN'(4);
   assign w_fetched  = {w_pc_plus4, imem_rdata};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= BOOT;
         r_pc         <= RESET_PC;
         r_ifid       <= '0;
         r_ifid_valid <= 1'b0;
         r_skid       <= '0;
      end else if (r_state == BOOT) begin
         r_state <= FETCH;
      end else if (w_redirect) begin
         r_state      <= FETCH;
         r_pc         <= w_target & ~XLEN'(3);
         r_ifid       <= {XLEN'(0), NOP_INSTR};
         r_ifid_valid <= 1'b0;
         r_skid       <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ready) begin
                  if (stall) begin
                     r_skid  <= w_fetched;
                     r_state <= HOLD;
                  end else begin
                     r_ifid       <= w_fetched;
                     r_ifid_valid <= 1'b1;
                     r_pc         <= w_pc_plus4;
                  end
               end
            end
            HOLD: begin
               if (!stall) begin
                  r_ifid       <= r_skid;
                  r_ifid_valid <= 1'b1;
                  r_pc         <= w_pc_plus4;
                  r_state      <= FETCH;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign imem_req   = (r_state == FETCH);
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign ifid_reg   = r_ifid;
   assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed test-plan scenarios followed by
// random traffic, checked against a transaction-level reference model.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] KEY    = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        jump_en;
   logic [31:0] jump_target;
   logic        branch_en;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic [63:0] ifid_reg;
   logic        ifid_valid;

   if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .stall(stall),
      .jump_en(jump_en), .jump_target(jump_target),
      .branch_en(branch_en), .branch_target(branch_target),
      .pc(pc), .ifid_reg(ifid_reg), .ifid_valid(ifid_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   // Memory answers for whatever address is shown this cycle.
   always_comb imem_rdata = mem_f(imem_addr);

   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] ifid;
      logic        valid;
      logic        req;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: PC, the visible IF/ID word, and instructions waiting for
   // a stall to clear (at most one).
   logic [31:0] m_pc;
   logic [63:0] m_ifid;
   logic        m_valid;
   logic        m_booted;
   logic [63:0] m_waiting[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_ifid = '0; m_valid = 1'b0; m_booted = 1'b0;
      m_waiting.delete();
   endtask

   task automatic model_step(input logic rdy, input logic st, input logic br,
                             input logic [31:0] bt, input logic jp, input logic [31:0] jt);
      logic [31:0] tgt;
      logic [63:0] word;
      if (!m_booted) begin
         m_booted = 1'b1;
      end else if (br || jp) begin
         tgt      = br ? bt : jt;
         m_pc     = {tgt[31:2], 2'b00};
         m_ifid   = {32'h0, NOP};
         m_valid  = 1'b0;
         m_waiting.delete();
      end else if (m_waiting.size() != 0) begin
         if (!st) begin
            m_ifid  = m_waiting.pop_front();
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end
      end else if (rdy) begin
         word = {m_pc + 32'd4, mem_f(m_pc)};
         if (st) m_waiting.push_back(word);
         else begin
            m_ifid  = word;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end
      end
   endtask

   // Apply one cycle of stimulus at a falling edge and queue what must follow.
   task automatic drive(input logic rdy, input logic st, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt);
      exp_t e;
      imem_ready = rdy; stall = st;
      branch_en = br; branch_target = bt;
      jump_en = jp; jump_target = jt;
      model_step(rdy, st, br, bt, jp, jt);
      e.pc    = m_pc;
      e.ifid  = m_ifid;
      e.valid = m_valid;
      e.req   = m_booted && (m_waiting.size() == 0);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: after every rising edge, compare whatever the model predicted.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc", 64'(pc), 64'(e.pc));
            check("imem_addr", 64'(imem_addr), 64'(e.pc));
            check("ifid_reg", ifid_reg, e.ifid);
            check("ifid_valid", 64'(ifid_valid), 64'(e.valid));
            check("imem_req", 64'(imem_req), 64'(e.req));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0;
      jump_en = 1'b0; jump_target = '0; branch_en = 1'b0; branch_target = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check("reset_pc", 64'(pc), 64'(RST_PC));
      check("reset_ifid", ifid_reg, 64'h0);
      check("reset_valid", 64'(ifid_valid), 64'h0);
      check("reset_req", 64'(imem_req), 64'h0);
      rst = 1'b0;

      // Stream
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      check("stream_first", ifid_reg, {32'h3004, 32'hA5A5_3000});
      check("stream_first_valid", 64'(ifid_valid), 64'h1);
      drive(1, 0, 0, 0, 0, 0);
      check("stream_second", ifid_reg, {32'h3008, 32'hA5A5_3004});
      check("stream_pc", 64'(pc), 64'h3008);

      // Stall with a response: held instruction appears once on release
      repeat (3) drive(1, 1, 0, 0, 0, 0);
      check("stall_frozen", ifid_reg, {32'h3008, 32'hA5A5_3004});
      check("stall_hold_req", 64'(imem_req), 64'h0);
      drive(1, 0, 0, 0, 0, 0);
      check("stall_release", ifid_reg, {32'h300C, 32'hA5A5_3008});
      drive(1, 0, 0, 0, 0, 0);
      check("stall_next", ifid_reg, {32'h3010, 32'hA5A5_300C});

      // Branch beats jump
      drive(1, 0, 1, 32'h4001, 1, 32'h5000);
      check("redir_pc", 64'(pc), 64'h4000);
      check("redir_bubble", 64'(ifid_valid), 64'h0);
      check("redir_nop", 64'(ifid_reg[31:0]), 64'(NOP));
      drive(1, 0, 0, 0, 0, 0);
      check("redir_target", ifid_reg, {32'h4004, 32'hA5A5_4000});

      // Redirect while holding a buffered instruction under stall
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 1, 32'h6000);
      check("hold_redir_pc", 64'(pc), 64'h6000);
      check("hold_redir_req", 64'(imem_req), 64'h1);
      drive(1, 0, 0, 0, 0, 0);
      check("hold_redir_target", ifid_reg, {32'h6004, 32'hA5A5_6000});

      // Wait states, then wrap past the top of the address space
      repeat (4) drive(0, 0, 0, 0, 0, 0);
      check("wait_ifid", ifid_reg, {32'h6004, 32'hA5A5_6000});
      check("wait_req", 64'(imem_req), 64'h1);
      drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
      drive(1, 0, 0, 0, 0, 0);
      check("wrap_ifid_hi", 64'(ifid_reg[63:32]), 64'h0);
      check("wrap_ifid_lo", 64'(ifid_reg[31:0]), 64'h5A5A_FFFC);
      check("wrap_pc", 64'(pc), 64'h0);

      // Asynchronous reset in the middle of HOLD
      drive(1, 1, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("async_valid", 64'(ifid_valid), 64'h0);
      check("async_req", 64'(imem_req), 64'h0);
      check("async_pc", 64'(pc), 64'(RST_PC));
      check("async_ifid", ifid_reg, 64'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 30),
               1'($urandom_range(99) < 5), $urandom,
               1'($urandom_range(99) < 6), $urandom);
      end
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
